// File: rtl/gen_frame_streamer.sv
// Frame-buffer feeder for the generator input: holds one IMG_WIDTH x IMG_HEIGHT frame
// and streams it in raster order with a programmable inter-pixel gap and backpressure.
module gen_frame_streamer #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  parameter int GAP_WIDTH  = 8,
  parameter int ADDR_W     = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic signed [DATA_WIDTH-1:0] wr_data,
  input  logic                         start,
  input  logic [GAP_WIDTH-1:0]         gap,
  input  logic                         ready_in,
  output logic                         valid_out,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         last_out,
  output logic                         busy,
  output logic                         done,
  output logic                         wr_err,
  output logic [2:0]                   state_dbg
);

  localparam int N = IMG_WIDTH * IMG_HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_SEND = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                         state_q, state_d;
  logic [ADDR_W-1:0]              idx_q, idx_d;
  logic [ADDR_W-1:0]              rd_addr;
  logic [GAP_WIDTH-1:0]           gap_q, gap_d;
  logic [GAP_WIDTH-1:0]           cnt_q, cnt_d;
  logic signed [DATA_WIDTH-1:0]   data_q, data_d;
  logic signed [DATA_WIDTH-1:0]   ram_q;
  logic                           wr_err_q;
  logic signed [DATA_WIDTH-1:0]   mem [N];
  logic                           wr_ok;
  logic                           hs;

  // Handshake: a pixel transfers on any rising edge where valid_out && ready_in;
  // valid_out never drops and data_out/last_out never change until that happens.
  assign valid_out = (state_q == S_SEND);
  assign hs        = valid_out && ready_in;
  assign busy      = (state_q == S_PREP) || (state_q == S_SEND) || (state_q == S_GAP);
  assign done      = (state_q == S_DONE);
  assign last_out  = valid_out && (idx_q == LAST_IDX);
  assign data_out  = data_q;
  assign wr_err    = wr_err_q;
  assign state_dbg = state_q;
  assign wr_ok     = wr_en && !busy;

  // Write-first read so a write in the start cycle is seen by the first pixel.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
    if (wr_ok && (wr_addr == rd_addr)) begin
      ram_q <= wr_data;
    end else begin
      ram_q <= mem[rd_addr];
    end
  end

  // ram_q always looks one pixel ahead of data_q so a handshake can refill at once.
  always_comb begin
    rd_addr = '0;
    case (state_q)
      S_PREP, S_GAP: rd_addr = idx_q + ADDR_W'(1);
      S_SEND:        rd_addr = hs ? (idx_q + ADDR_W'(2)) : (idx_q + ADDR_W'(1));
      default:       rd_addr = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d = S_PREP;
          gap_d   = gap;
          idx_d   = '0;
        end
      end
      S_PREP: begin
        state_d = S_SEND;
        data_d  = ram_q;
      end
      S_SEND: begin
        if (hs) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d  = idx_q + ADDR_W'(1);
            data_d = ram_q;
            if (gap_q != '0) begin
              state_d = S_GAP;
              cnt_d   = gap_q;
            end
          end
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_WIDTH'(1)) begin
          state_d = S_SEND;
        end else begin
          cnt_d = cnt_q - GAP_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      gap_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      wr_err_q <= wr_en && busy;
    end
  end

endmodule

// File: tb/tb_gen_frame_streamer.sv
// Self-checking bench for gen_frame_streamer: scoreboard of expected pixels fed at start,
// negedge monitor comparing every handshake, timing, stall stability, done and wr_err.
module tb_gen_frame_streamer;

  localparam int DW = 16;
  localparam int IW = 32;
  localparam int IH = 32;
  localparam int GW = 8;
  localparam int AW = 10;
  localparam int N  = IW * IH;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic [GW-1:0] gap_in;
  logic          ready_in;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic          last_out;
  logic          busy;
  logic          done;
  logic          wr_err;
  logic [2:0]    state_dbg;

  gen_frame_streamer #(
    .DATA_WIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .GAP_WIDTH(GW)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .gap(gap_in), .ready_in(ready_in), .valid_out(valid_out),
    .data_out(data_out), .last_out(last_out), .busy(busy), .done(done),
    .wr_err(wr_err), .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model and scoreboard
  logic [DW-1:0] ref_mem [N];
  logic [DW:0]   exp_q[$];
  int tests_run = 0;
  int fails = 0;
  int hs_idx = 0, frame_start = 0, frame_gap = 0, last_hs_cyc = 0;
  int done_cnt = 0, wr_err_cnt = 0;
  bit chk_timing = 1'b0;
  bit prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // monitor
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_hold", {31'd0, valid_out}, 32'd1);
        check("stall_data_hold", {16'd0, data_out}, {16'd0, prev_data});
        check("stall_last_hold", {31'd0, last_out}, {31'd0, prev_last});
      end
      if (valid_out && ready_in) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          fails++;
          $display("FAIL unexpected_pixel: actual %0h expected none", data_out);
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          check("px_data", {16'd0, data_out}, {16'd0, e[DW-1:0]});
          check("px_last", {31'd0, last_out}, {31'd0, e[DW]});
        end
        if (chk_timing)
          check("px_time", cyc, frame_start + 2 + hs_idx * (frame_gap + 1));
        hs_idx++;
        last_hs_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        check("done_time", cyc, last_hs_cyc + 1);
        check("done_drained", exp_q.size(), 0);
        check("done_busy_low", {31'd0, busy}, 32'd0);
      end
      if (wr_err) wr_err_cnt++;
      prev_stall = valid_out && !ready_in;
      prev_data  = data_out;
      prev_last  = last_out;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_px(input int addr, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = AW'(addr); wr_data = d;
    ref_mem[addr] = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic start_frame(input int g);
    for (int i = 0; i < N; i++) exp_q.push_back({(i == N - 1), ref_mem[i]});
    gap_in = GW'(g); start = 1'b1;
    frame_start = cyc; frame_gap = g; hs_idx = 0;
    tick();
    start = 1'b0; wr_en = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("no_valid_in_prep", {31'd0, valid_out}, 32'd0);
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int  d0 = done_cnt;
    bit  ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (rnd) ready_in = 1'($urandom_range(0, 1));
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
    end
    ready_in = 1'b1;
    tests_run++;
    if (!ok) begin
      fails++;
      $display("FAIL frame_timeout: actual no done expected done within %0d cycles", budget);
    end
  endtask

  initial begin
    int wr0, d0, dc0;
    bit found;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; gap_in = '0; ready_in = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_data", {16'd0, data_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_state_idle", {29'd0, state_dbg}, 32'd0);

    // ramp frame, full throughput
    for (int i = 0; i < N; i++) write_px(i, 16'(i - 512));
    chk_timing = 1'b1;
    start_frame(0);
    wait_done(2000, 1'b0);

    // gap = 3, gap input changed mid-frame must not matter
    start_frame(3);
    gap_in = GW'($urandom_range(0, 255));
    wait_done(5000, 1'b0);

    // random backpressure
    chk_timing = 1'b0;
    start_frame(0);
    wait_done(8000, 1'b1);

    // busy protection: dropped write and ignored start
    wr0 = wr_err_cnt; d0 = done_cnt;
    chk_timing = 1'b1;
    start_frame(0);
    repeat (10) tick();
    start = 1'b1; wr_en = 1'b1; wr_addr = AW'(5); wr_data = 16'h1234;
    tick();
    start = 1'b0; wr_en = 1'b0;
    wait_done(2000, 1'b0);
    check("wr_err_pulses", wr_err_cnt - wr0, 1);
    check("single_done", done_cnt - d0, 1);

    // reset while pixel 100 is presented
    start_frame(0);
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (valid_out && data_out == ref_mem[100]) begin
        found = 1'b1;
        break;
      end
    end
    check("reached_px100", {31'd0, found}, 32'd1);
    rst = 1'b1;
    dc0 = done_cnt;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("abort_valid", {31'd0, valid_out}, 32'd0);
    check("abort_data", {16'd0, data_out}, 32'd0);
    check("abort_last", {31'd0, last_out}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_wr_err", {31'd0, wr_err}, 32'd0);
    repeat (3) tick();
    check("abort_no_done", done_cnt - dc0, 0);
    start_frame(0);
    wait_done(2000, 1'b0);

    // write and start in the same idle cycle
    wr_en = 1'b1; wr_addr = '0; wr_data = 16'h7fff;
    ref_mem[0] = 16'h7fff;
    start_frame(0);
    tick();
    check("same_cycle_px0", {16'd0, data_out}, 32'h7fff);
    wait_done(2000, 1'b0);

    // random contents, random gap, random backpressure
    chk_timing = 1'b0;
    for (int i = 0; i < N; i++) write_px(i, 16'($urandom));
    start_frame($urandom_range(0, 2));
    wait_done(12000, 1'b1);

    repeat (3) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
